// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: forwarding, stall/flush and data-memory wait sequencing for the 5-stage ARM pipeline
module pipeline_hazard_ctrl #(
  parameter int          MEM_TIMEOUT = 16,
  parameter logic [31:0] STALL_INIT  = '0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  RA1D,
  input  logic [3:0]  RA2D,
  input  logic [3:0]  RA1E,
  input  logic [3:0]  RA2E,
  input  logic [3:0]  WA3E,
  input  logic [3:0]  WA3M,
  input  logic [3:0]  WA3W,
  input  logic        RegWriteE,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        MemtoRegE,
  input  logic        branchLinkW,
  input  logic        PCSrcD,
  input  logic        PCSrcE,
  input  logic        PCSrcM,
  input  logic        PCSrcW,
  input  logic        BranchTakenE,
  input  logic        MemReqM,
  input  logic        MemReadyM,
  input  logic        ErrClr,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushW,
  output logic        MemErr,
  output logic [31:0] StallCycles
);
  localparam logic [15:0] TO = 16'(MEM_TIMEOUT);
  typedef enum logic {RUN, WAIT} state_t;
  state_t state;
  logic [15:0] cnt;
  logic at_limit, mem_stall, timeout, ldr_stall, pc_wr_pending;
  function automatic logic [1:0] fwd(input logic [3:0] ra);
    return ra == 4'd15 ? 2'b00 :
           (RegWriteM && ra == WA3M) ? 2'b10 :
           ((RegWriteW && ra == WA3W) || (branchLinkW && ra == 4'd14)) ? 2'b01 : 2'b00;
  endfunction
  always_comb begin
    at_limit      = state == WAIT && cnt == TO;
    mem_stall     = MemReqM & ~MemReadyM & ~at_limit;
    timeout       = at_limit & ~MemReadyM;
    ldr_stall     = MemtoRegE & RegWriteE & (RA1D == WA3E || RA2D == WA3E);
    pc_wr_pending = PCSrcD | PCSrcE | PCSrcM;
    ForwardAE     = reset ? 2'b00 : fwd(RA1E);
    ForwardBE     = reset ? 2'b00 : fwd(RA2E);
    StallF        = reset ? 1'b0 : mem_stall ? 1'b1 : timeout ? 1'b0 : ldr_stall | pc_wr_pending;
    StallD        = reset ? 1'b0 : mem_stall ? 1'b1 : timeout ? 1'b0 : ldr_stall;
    StallE        = ~reset & mem_stall;
    StallM        = ~reset & mem_stall;
    FlushD        = reset | (~mem_stall & (pc_wr_pending | PCSrcW | BranchTakenE));
    FlushE        = reset | (~mem_stall & (ldr_stall | BranchTakenE));
    FlushW        = reset | mem_stall | timeout;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      cnt         <= '0;
      MemErr      <= 1'b0;
      StallCycles <= STALL_INIT;
    end else begin
      if (state == RUN) begin
        if (mem_stall) begin
          state <= WAIT;
          cnt   <= 16'd1;
        end
      end else if (MemReadyM || timeout) begin
        state <= RUN;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 16'd1;
      end
      MemErr <= timeout | (MemErr & ~ErrClr);
      if (StallD && StallCycles != '1) StallCycles <= StallCycles + 32'd1;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed vectors for pipeline_hazard_ctrl with MEM_TIMEOUT = 4
module tb_pipeline_hazard_ctrl;
  logic clk = 0, reset = 1;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE, branchLinkW;
  logic PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MemReqM, MemReadyM, ErrClr;
  logic [1:0] ForwardAE, ForwardBE, s_fa, s_fb;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
  logic s_sf, s_sd, s_se, s_sm, s_fd, s_fe, s_fw, s_me;
  logic [31:0] StallCycles, s_cycles;
  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE), .branchLinkW(branchLinkW),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE), .MemReqM(MemReqM), .MemReadyM(MemReadyM), .ErrClr(ErrClr),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallF(StallF), .StallD(StallD),
    .StallE(StallE), .StallM(StallM), .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .MemErr(MemErr), .StallCycles(StallCycles));

  // Second instance starts its counter next to the ceiling so saturation is reachable.
  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .STALL_INIT(32'hFFFF_FFFE)) sat (
    .clk(clk), .reset(reset), .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE), .branchLinkW(branchLinkW),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE), .MemReqM(MemReqM), .MemReadyM(MemReadyM), .ErrClr(ErrClr),
    .ForwardAE(s_fa), .ForwardBE(s_fb), .StallF(s_sf), .StallD(s_sd),
    .StallE(s_se), .StallM(s_sm), .FlushD(s_fd), .FlushE(s_fe), .FlushW(s_fw),
    .MemErr(s_me), .StallCycles(s_cycles));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    {RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W} = '0;
    {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, branchLinkW} = '0;
    {PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MemReqM, MemReadyM, ErrClr} = '0;
  endtask

  initial begin
    clear();
    RA1E = 4'd3; WA3M = 4'd3; RegWriteM = 1;
    tick();
    #1;
    check("rst_flush", {29'd0, FlushD, FlushE, FlushW}, 32'h7);
    check("rst_stall", {28'd0, StallF, StallD, StallE, StallM}, 32'h0);
    check("rst_fwd", {30'd0, ForwardAE}, 32'h0);
    tick();
    reset = 0;
    clear();
    #1;
    check("rst_memerr", {31'd0, MemErr}, 32'h0);
    check("rst_cycles", StallCycles, 32'h0);
    check("idle_flush", {29'd0, FlushD, FlushE, FlushW}, 32'h0);

    RA1E = 4'd3; WA3M = 4'd3; RegWriteM = 1; WA3W = 4'd3; RegWriteW = 1;
    #1 check("fwd_m", {30'd0, ForwardAE}, 32'h2);
    RegWriteM = 0;
    #1 check("fwd_w", {30'd0, ForwardAE}, 32'h1);
    RA1E = 4'd15;
    #1 check("fwd_r15", {30'd0, ForwardAE}, 32'h0);
    branchLinkW = 1; RA2E = 4'd14;
    #1 check("fwd_bl", {30'd0, ForwardBE}, 32'h1);
    clear();

    MemtoRegE = 1; RegWriteE = 1; WA3E = 4'd5; RA2D = 4'd5;
    #1 check("ldr_stall", {28'd0, StallF, StallD, FlushE, FlushD}, 32'hE);
    tick();
    clear();
    #1 check("ldr_cycles", StallCycles, 32'd1);

    BranchTakenE = 1;
    #1 check("br_flush", {30'd0, FlushD, FlushE}, 32'h3);
    clear();
    PCSrcD = 1;
    #1 check("pcsrcd", {29'd0, StallF, FlushD, StallD}, 32'h6);
    clear();

    MemReqM = 1;
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("wait_stall%0d", i), {27'd0, StallF, StallD, StallE, StallM, FlushW}, 32'h1F);
      tick();
    end
    MemReadyM = 1;
    #1 check("wait_release", {27'd0, StallF, StallD, StallE, StallM, FlushW}, 32'h0);
    tick();
    clear();
    #1 check("wait_memerr", {31'd0, MemErr}, 32'h0);
    check("wait_cycles", StallCycles, 32'd4);

    MemReqM = 1;
    for (int i = 0; i < 4; i++) begin
      #1 check($sformatf("to_stall%0d", i), {30'd0, StallD, StallM}, 32'h3);
      tick();
    end
    #1 check("to_cycle", {28'd0, StallF, StallD, StallM, FlushW}, 32'h1);
    check("to_err_pre", {31'd0, MemErr}, 32'h0);
    tick();
    MemReqM = 0;
    #1 check("to_err", {31'd0, MemErr}, 32'h1);
    check("to_after", {30'd0, StallD, FlushW}, 32'h0);
    ErrClr = 1;
    tick();
    ErrClr = 0;
    #1 check("errclr", {31'd0, MemErr}, 32'h0);
    check("to_cycles", StallCycles, 32'd8);

    MemReqM = 1;
    repeat (4) tick();
    ErrClr = 1;
    #1 check("to2_cycle", {30'd0, StallD, FlushW}, 32'h1);
    tick();
    MemReqM = 0;
    #1 check("set_wins", {31'd0, MemErr}, 32'h1);
    tick();
    ErrClr = 0;
    #1 check("set_clr", {31'd0, MemErr}, 32'h0);

    MemReqM = 1; MemReadyM = 1;
    #1 check("ready_first", {29'd0, StallD, StallM, FlushW}, 32'h0);
    tick();
    MemReadyM = 0;
    #1 check("b2b_stall", {30'd0, StallM, FlushW}, 32'h3);
    tick();
    reset = 1;
    #1 check("midwait_rst", {28'd0, FlushD, FlushE, FlushW, StallM}, 32'hE);
    tick();
    reset = 0;
    #1 check("midwait_err", {31'd0, MemErr}, 32'h0);
    check("midwait_cnt0", StallCycles, 32'h0);
    for (int i = 0; i < 4; i++) begin
      #1 check($sformatf("rerun_stall%0d", i), {30'd0, StallD, FlushW}, 32'h3);
      tick();
    end
    #1 check("rerun_to", {30'd0, StallD, FlushW}, 32'h1);
    tick();
    MemReqM = 0;
    #1 check("main_cycles", StallCycles, 32'd4);
    check("sat_cycles", s_cycles, 32'hFFFF_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and stall scheduler for the 5-stage 32-bit ARM pipeline. Generates forwarding selects, stall enables and flush (bubble) controls for the Fetch, Decode, Execute, Memory and Writeback pipeline registers, including the Mem-to-WB register.

It also sequences the data-memory wait handshake. A memory timeout watchdog and a stall-cycle performance counter run alongside.

## Interface
- MEM_TIMEOUT, 16: maximum number of consecutive cycles the pipeline stalls on one unanswered memory access (1..65535).
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- RA1D, RA2D  in  4 each  Decode-stage source register numbers.
- RA1E, RA2E  in  4 each  Execute-stage source register numbers.
- WA3E, WA3M, WA3W  in  4 each  destination register numbers in E, M and W.
- RegWriteE, RegWriteM, RegWriteW  in  1 each  register-write valid per stage.
- MemtoRegE  in  1  load in Execute.
- branchLinkW  in  1  Writeback writes PCPlus4W to R14.
- PCSrcD, PCSrcE, PCSrcM, PCSrcW  in  1 each  PC-write instruction in stage.
- BranchTakenE  in  1  branch resolved taken in Execute.
- MemReqM  in  1  load/store active in Memory.
- MemReadyM  in  1  data memory completes the access this cycle.
- ErrClr  in  1  clears MemErr.
- ForwardAE, ForwardBE  out  2 each  00 = register file, 01 = Writeback result, 10 = ALUOutM.
- StallF, StallD, StallE, StallM  out  1 each  hold the stage register.
- FlushD, FlushE, FlushW  out  1 each  load a bubble into the stage register.
- MemErr  out  1  sticky memory timeout flag.
- StallCycles  out  32  saturating count of cycles with StallD = 1.

## Operation
- **Forwarding (combinational), per operand X ∈ {1,2}:**
  - If RAXE == 15, the select is 00.
  - Else if RegWriteM and RAXE == WA3M, the select is 10.
  - Else if (RegWriteW and RAXE == WA3W) or (branchLinkW and RAXE == 14), the select is 01.
  - Otherwise the select is 00.
- **ldrStall:** asserted when MemtoRegE and RegWriteE are high and (RA1D == WA3E or RA2D == WA3E).
- **PCWrPending:** PCSrcD | PCSrcE | PCSrcM.
- **Memory FSM:**
  - States: RUN and WAIT, plus a 16-bit wait counter cnt.
  - MemStall = MemReqM & ~MemReadyM & ~(state == WAIT & cnt == MEM_TIMEOUT).
  - RUN: if MemStall, go to WAIT with cnt = 1.
  - WAIT, MemReadyM = 1: go to RUN, cnt = 0.
  - WAIT, MemReadyM = 0 and cnt < MEM_TIMEOUT: stay in WAIT, cnt + 1.
  - WAIT, MemReadyM = 0 and cnt == MEM_TIMEOUT (timeout): go to RUN, cnt = 0, MemErr ← 1. The access is abandoned.
- **Output priority 1, MemStall = 1:**
  - StallF = StallD = StallE = StallM = 1.
  - FlushD = FlushE = 0.
  - FlushW = 1.
- **Output priority 2, timeout cycle:**
  - All stalls are 0.
  - FlushW = 1, dropping the abandoned access.
  - FlushD and FlushE follow priority 3.
- **Output priority 3, otherwise:**
  - StallF = ldrStall | PCWrPending.
  - StallD = ldrStall.
  - StallE = StallM = 0.
  - FlushD = PCWrPending | PCSrcW | BranchTakenE.
  - FlushE = ldrStall | BranchTakenE.
  - FlushW = 0.
- **MemErr:**
  - Set on timeout.
  - Cleared by ErrClr.
  - If both occur in the same cycle, the set wins.
- **StallCycles:** increments every cycle StallD = 1 and holds at 0xFFFFFFFF.

## Timing
- Forwarding, stall and flush outputs are combinational from the inputs and the registered FSM state. They have zero-cycle latency.
- **Reset:**
  - State RUN, cnt 0, MemErr 0, StallCycles 0.
  - While reset is high: all stalls 0, FlushD = FlushE = FlushW = 1, forwards 00.
- **Reset mid-WAIT:**
  - The next cycle is RUN with cnt 0.
  - No MemErr is set and the partial access is abandoned.
- **Stall length:** one unanswered access stalls for exactly MEM_TIMEOUT cycles. The following cycle is the release/timeout cycle.
- **MemReadyM in the first request cycle:** no stall and no state change.
- **Back-to-back accesses:** a new request is judged in RUN on the cycle after completion.

## Test plan
- **Forwarding:** RA1E = 3, WA3M = 3, RegWriteM = 1, and also WA3W = 3, RegWriteW = 1 -> ForwardAE = 10. Drop RegWriteM -> 01. Set RA1E = 15 -> 00. Set branchLinkW = 1, RA2E = 14 -> ForwardBE = 01.
- **Load-use:** MemtoRegE = RegWriteE = 1, WA3E = 5, RA2D = 5 -> StallF = StallD = FlushE = 1, FlushD = 0. StallCycles increments by 1.
- **Branch:** BranchTakenE = 1 -> FlushD = FlushE = 1. PCSrcD = 1 alone -> StallF = FlushD = 1, StallD = 0.
- **Memory wait:** MemReqM = 1 with MemReadyM low for 3 cycles, then high -> StallF..M and FlushW high for exactly 3 cycles. Then all stalls 0 and MemErr = 0.
- **Timeout:** MEM_TIMEOUT = 4, MemReadyM held low -> 4 stall cycles, then one cycle with stalls 0 and FlushW = 1. MemErr = 1 the cycle after. ErrClr -> MemErr = 0.
- **Reset mid-wait, with counter saturation:** reset asserted during cycle 2 of WAIT -> RUN, cnt 0, MemErr 0, all flushes 1 during reset. Separately, preload StallCycles to 0xFFFFFFFE and stall 3 cycles -> it holds at 0xFFFFFFFF.
